// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: the requesting side of the CP0 exception interface.
// Optional build macro EXC_CTRL_TIMER_EN lets the CP0 timer flag act as IP7.
module exc_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] status,
   input  logic [31:0] cause,
   input  logic [31:0] epc,
   input  logic        intimer,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_syscall,
   input  logic        mem_eret,
   output logic [31:0] excptype,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam logic [31:0] CODE_INT  = 32'h0000_0004;
   localparam logic [31:0] CODE_SYS  = 32'h0000_0100;
   localparam logic [31:0] CODE_ERET = 32'h0000_0200;

   typedef enum logic [1:0] {IDLE, TAKE, REDIRECT} state_t;
   typedef enum logic [1:0] {K_INT, K_SYS, K_ERET} kind_t;

   state_t      state_q;
   kind_t       kind_q;
   logic [31:0] excptype_q;
   logic [31:0] exc_pc_q;
   logic        flush_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;
   logic        busy_q;

   logic        int_req;
   logic        int_src;
   logic        unused_bits;

`ifdef EXC_CTRL_TIMER_EN
   assign int_src = (|(cause[15:8] & status[15:8])) | (intimer & status[15]);
`else
   assign int_src = |(cause[15:8] & status[15:8]);
`endif
   assign int_req = status[0] & ~status[1] & int_src;

   assign unused_bits = ^{status[31:16], status[7:2], cause[31:16], cause[7:0], intimer};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         kind_q           <= K_INT;
         excptype_q       <= '0;
         exc_pc_q         <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         busy_q           <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               excptype_q       <= '0;
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               busy_q           <= 1'b0;
               // Pending interrupts are not latched; only a real MEM instruction can carry one.
               if (mem_valid && (int_req || mem_syscall || mem_eret)) begin
                  state_q  <= TAKE;
                  exc_pc_q <= mem_pc;
                  flush_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  if (int_req) begin
                     kind_q     <= K_INT;
                     excptype_q <= CODE_INT;
                  end else if (mem_syscall) begin
                     kind_q     <= K_SYS;
                     excptype_q <= CODE_SYS;
                  end else begin
                     kind_q     <= K_ERET;
                     excptype_q <= CODE_ERET;
                  end
               end
            end
            TAKE: begin
               // excptype drops after one cycle so CP0 commits EPC/EXL exactly once.
               state_q          <= REDIRECT;
               excptype_q       <= '0;
               flush_q          <= 1'b1;
               busy_q           <= 1'b1;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= (kind_q == K_ERET) ? epc : HANDLER_ADDR;
            end
            REDIRECT: begin
               state_q          <= IDLE;
               excptype_q       <= '0;
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               busy_q           <= 1'b0;
            end
            default: begin
               state_q          <= IDLE;
               excptype_q       <= '0;
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               busy_q           <= 1'b0;
            end
         endcase
      end
   end

   assign excptype       = excptype_q;
   assign exc_pc         = exc_pc_q;
   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed, table-driven bench for exc_ctrl plus hand sequences for reset, busy and deferred interrupts.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] status, cause, epc, mem_pc;
   logic        intimer, mem_valid, mem_syscall, mem_eret;
   logic [31:0] excptype, exc_pc, redirect_pc;
   logic        flush, redirect_valid, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   exc_ctrl #(.HANDLER_ADDR(32'h0000_0040)) dut (
      .clk(clk), .rst(rst), .status(status), .cause(cause), .epc(epc),
      .intimer(intimer), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_syscall(mem_syscall), .mem_eret(mem_eret),
      .excptype(excptype), .exc_pc(exc_pc), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct {
      string       name;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc_n;
      logic [31:0] epc_n1;
      logic        intimer;
      logic        valid;
      logic [31:0] pc;
      logic        sys;
      logic        eret;
      logic [31:0] exp_code;
      logic [31:0] exp_rpc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      status = '0; cause = '0; intimer = 1'b0;
      mem_valid = 1'b0; mem_pc = '0; mem_syscall = 1'b0; mem_eret = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".excptype"}, excptype, 32'h0);
      chk({tag, ".flush"}, {31'b0, flush}, 32'h0);
      chk({tag, ".rv"}, {31'b0, redirect_valid}, 32'h0);
      chk({tag, ".busy"}, {31'b0, busy}, 32'h0);
   endtask

   task automatic chk_take(input string tag, input logic [31:0] code, input logic [31:0] pc);
      chk({tag, ".N1.excptype"}, excptype, code);
      chk({tag, ".N1.exc_pc"}, exc_pc, pc);
      chk({tag, ".N1.flush"}, {31'b0, flush}, 32'h1);
      chk({tag, ".N1.rv"}, {31'b0, redirect_valid}, 32'h0);
      chk({tag, ".N1.busy"}, {31'b0, busy}, 32'h1);
   endtask

   task automatic chk_redirect(input string tag, input logic [31:0] rpc);
      chk({tag, ".N2.excptype"}, excptype, 32'h0);
      chk({tag, ".N2.flush"}, {31'b0, flush}, 32'h1);
      chk({tag, ".N2.rv"}, {31'b0, redirect_valid}, 32'h1);
      chk({tag, ".N2.rpc"}, redirect_pc, rpc);
      chk({tag, ".N2.busy"}, {31'b0, busy}, 32'h1);
   endtask

   initial begin
      logic [31:0] timer_code;
`ifdef EXC_CTRL_TIMER_EN
      timer_code = 32'h4;
`else
      timer_code = 32'h0;
`endif
      //          name        status        cause         epc_n         epc_n1        tmr   vld   pc            sys   eret  code      rpc
      vecs[0] = '{"syscall",  32'h0000_0000, 32'h0,       32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h100, 32'h40};
      vecs[1] = '{"eret",     32'h0000_0000, 32'h0,       32'h0000_0999, 32'h0000_0104, 1'b0, 1'b1, 32'h0000_0180, 1'b0, 1'b1, 32'h200, 32'h104};
      vecs[2] = '{"int",      32'h0000_0401, 32'h400,     32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h4,   32'h40};
      vecs[3] = '{"int_exl",  32'h0000_0403, 32'h400,     32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0204, 1'b0, 1'b0, 32'h0,   32'h0};
      vecs[4] = '{"int_im0",  32'h0000_0001, 32'h400,     32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0208, 1'b0, 1'b0, 32'h0,   32'h0};
      vecs[5] = '{"int_ie0",  32'h0000_0400, 32'h400,     32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_020c, 1'b0, 1'b0, 32'h0,   32'h0};
      vecs[6] = '{"int_sys",  32'h0000_0401, 32'h400,     32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h4,   32'h40};
      vecs[7] = '{"sys_eret", 32'h0000_0000, 32'h0,       32'h0000_0500, 32'h0000_0500, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h100, 32'h40};
      vecs[8] = '{"timer",    32'h0000_8001, 32'h0,       32'h0,        32'h0,        1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b0, timer_code, 32'h40};
      vecs[9] = '{"sys_bub",  32'h0000_0000, 32'h0,       32'h0,        32'h0,        1'b0, 1'b0, 32'h0000_0700, 1'b1, 1'b0, 32'h0,   32'h0};

      // Reset held two cycles with a Syscall presented.
      clear_in(); epc = '0;
      rst = 1'b1; mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h100;
      step(); chk_quiet("rst1"); chk("rst1.exc_pc", exc_pc, 32'h0); chk("rst1.rpc", redirect_pc, 32'h0);
      step(); chk_quiet("rst2"); chk("rst2.exc_pc", exc_pc, 32'h0); chk("rst2.rpc", redirect_pc, 32'h0);
      clear_in(); rst = 1'b0;
      step(); chk_quiet("idle0");

      foreach (vecs[i]) begin
         status = vecs[i].status; cause = vecs[i].cause; epc = vecs[i].epc_n;
         intimer = vecs[i].intimer; mem_valid = vecs[i].valid; mem_pc = vecs[i].pc;
         mem_syscall = vecs[i].sys; mem_eret = vecs[i].eret;
         step();
         clear_in(); epc = vecs[i].epc_n1;
         if (vecs[i].exp_code != 32'h0) begin
            chk_take(vecs[i].name, vecs[i].exp_code, vecs[i].pc);
            step(); chk_redirect(vecs[i].name, vecs[i].exp_rpc);
            step(); chk_quiet({vecs[i].name, ".N3"});
         end else begin
            chk_quiet({vecs[i].name, ".N1"});
            step(); chk_quiet({vecs[i].name, ".N2"});
         end
      end

      // Pending interrupt with a bubble in MEM is deferred until a valid instruction arrives.
      clear_in(); status = 32'h401; cause = 32'h400; mem_pc = 32'h800;
      step(); chk_quiet("defer.1");
      step(); chk_quiet("defer.2");
      mem_valid = 1'b1;
      step(); clear_in();
      chk_take("defer", 32'h4, 32'h800);
      step(); chk_redirect("defer", 32'h40);
      step(); chk_quiet("defer.N3");

      // Syscall held valid: ignored in N+1 and N+2, accepted again at N+3.
      mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h900;
      step(); chk_take("hold", 32'h100, 32'h900);
      mem_pc = 32'h904;
      step(); chk_redirect("hold", 32'h40);
      mem_pc = 32'h908;
      step(); chk_quiet("hold.N3");
      mem_pc = 32'h90c;
      step(); clear_in();
      chk_take("hold2", 32'h100, 32'h90c);
      step(); chk_redirect("hold2", 32'h40);
      step(); chk_quiet("hold2.N3");

      // Reset during TAKE drops the half-issued event.
      mem_valid = 1'b1; mem_eret = 1'b1; mem_pc = 32'ha00; epc = 32'h123;
      step(); clear_in();
      chk_take("rstmid", 32'h200, 32'ha00);
      rst = 1'b1;
      step(); rst = 1'b0;
      chk_quiet("rstmid.r"); chk("rstmid.exc_pc", exc_pc, 32'h0);
      step(); chk_quiet("rstmid.after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer; the requesting end of the CP0 exception interface.
- Watches the MEM-stage instruction and CP0 status/cause, and decides when to take a hardware interrupt, Syscall or Eret.
- Drives a one-cycle excptype/pc pair into CP0, flushes the pipeline and redirects fetch to the handler or to EPC.
- Sits beside CP0, between the MEM stage and the PC/IF logic.

Parameters:
- HANDLER_ADDR, 32'h0000_0040, fetch address of the common exception/interrupt handler.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- status  input  32  CP0 Status; [15:8] IM, [1] EXL, [0] IE.
- cause  input  32  CP0 Cause; [15:8] IP.
- epc  input  32  CP0 EPC, used as the Eret return target.
- intimer  input  1  CP0 timer interrupt flag.
- mem_valid  input  1  MEM stage holds a real, non-bubble instruction.
- mem_pc  input  32  PC of the MEM-stage instruction.
- mem_syscall  input  1  MEM instruction is Syscall.
- mem_eret  input  1  MEM instruction is Eret.
- excptype  output  32  to CP0; 32'h4 = interrupt, 32'h100 = Syscall, 32'h200 = Eret, 0 = none.
- exc_pc  output  32  to CP0 pc input; PC of the excepting instruction.
- flush  output  1  kill the IF–MEM stages.
- redirect_valid  output  1  one-cycle pulse; load redirect_pc into PC.
- redirect_pc  output  32  new fetch address.
- busy  output  1  sequencer is not in IDLE.

Behaviour:
- Reset: state = IDLE; excptype = 0, exc_pc = 0, flush = 0, redirect_valid = 0, redirect_pc = 0, busy = 0. All outputs are registered.
- Interrupt request: int_req = status[0] & ~status[1] & |(cause[15:8] & status[15:8]). This is combinational, evaluated every cycle.
- Priority in IDLE, applied only when mem_valid = 1: int_req > mem_syscall > mem_eret.
- A pending interrupt with mem_valid = 0 is not taken and not latched; it is re-evaluated each cycle until a valid instruction reaches MEM.
- States: IDLE -> TAKE -> REDIRECT -> IDLE.
- IDLE, event accepted at cycle N (edge ending N):
  - latch kind and mem_pc;
  - go to TAKE.
- TAKE (cycle N+1):
  - excptype = code for the latched kind, exactly 1 cycle;
  - exc_pc = latched mem_pc (CP0 adds 4 itself for Syscall);
  - flush = 1, busy = 1.
- REDIRECT (cycle N+2):
  - excptype = 0, flush = 1, redirect_valid = 1, busy = 1;
  - redirect_pc = HANDLER_ADDR for interrupt or Syscall;
  - redirect_pc = epc sampled in N+1 for Eret.
- IDLE (N+3): all pulses deasserted.
- Total: 3 cycles from acceptance to the first handler fetch; the next event can be accepted at the earliest in N+3.
- mem_syscall/mem_eret/int_req while busy are ignored; those instructions are being flushed.
- mem_syscall and mem_eret both high: Syscall wins.
- Interrupt and Syscall in the same cycle: interrupt taken; Syscall re-executes after Eret.
- excptype is never held for more than 1 cycle, so CP0 EPC/EXL update exactly once per event.
- rst in any state returns to IDLE next edge with all outputs cleared; a half-issued event is dropped.
- Unused excptype bits are always 0.

Optional Feature:
- Macro: EXC_CTRL_TIMER_EN.
- Defined: int_req additionally ORs in intimer & status[15] (timer acts as IP7), still gated by IE and ~EXL. The same priority and mem_valid rules apply.
- Undefined: intimer is ignored; the timer can interrupt only if it is externally wired into cause[15:10].

Test Plan:
- Reset: hold rst 2 cycles with mem_syscall = 1 -> all outputs 0, busy = 0 throughout.
- Syscall: mem_valid = 1, mem_syscall = 1, mem_pc = 32'h0000_0100 at N -> at N+1, excptype = 32'h100 (1 cycle) and exc_pc = 32'h100; at N+2, redirect_valid = 1 and redirect_pc = 32'h40; flush high in N+1..N+2.
- Eret: epc = 32'h0000_0104, mem_eret = 1 at N -> excptype = 32'h200 at N+1; redirect_pc = 32'h104 at N+2.
- Interrupt gating: cause[10] = 1, status = 32'h0000_0401 -> taken when mem_valid = 1, excptype = 32'h4.
  - Same with status[1] = 1 -> no event.
  - Same with status[10] = 0 -> no event.
  - Same with mem_valid = 0 -> no event until mem_valid rises.
- Priority/busy: interrupt and Syscall together -> excptype = 32'h4 only. A second Syscall in N+1 or N+2 is ignored; a Syscall at N+3 is accepted.
- Timer: with EXC_CTRL_TIMER_EN, intimer = 1 and status = 32'h0000_8001 -> excptype = 32'h4. Without the macro -> no event.
